// File: rtl/circuit2_operand_sequencer.sv
// Operand sequencer in front of circuit2: packs a serial word stream into (a, b, c),
// holds the triple through circuit2's register stage, then hands the z/x pair downstream.
module circuit2_operand_sequencer #(
    parameter int DATAWIDTH = 32,
    parameter int CNTWIDTH  = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic signed [DATAWIDTH-1:0] in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic signed [DATAWIDTH-1:0] a,
    output logic signed [DATAWIDTH-1:0] b,
    output logic signed [DATAWIDTH-1:0] c,
    input  logic signed [DATAWIDTH-1:0] z_in,
    input  logic signed [DATAWIDTH-1:0] x_in,
    output logic signed [DATAWIDTH-1:0] res_z,
    output logic signed [DATAWIDTH-1:0] res_x,
    output logic                        res_valid,
    input  logic                        res_ready,
    output logic                        busy,
    output logic [CNTWIDTH-1:0]         triple_count
);

    typedef enum logic [2:0] {
        LOAD_A  = 3'd0,
        LOAD_B  = 3'd1,
        LOAD_C  = 3'd2,
        SETTLE  = 3'd3,
        CAPTURE = 3'd4,
        OUT     = 3'd5
    } state_t;

    state_t                        r_state;
    state_t                        w_next;
    logic signed [DATAWIDTH-1:0]   r_a;
    logic signed [DATAWIDTH-1:0]   r_b;
    logic signed [DATAWIDTH-1:0]   r_c;
    logic signed [DATAWIDTH-1:0]   r_res_z;
    logic signed [DATAWIDTH-1:0]   r_res_x;
    logic [CNTWIDTH-1:0]           r_count;
    logic                          w_in_ready;
    logic                          w_res_valid;
    logic                          w_load_a;
    logic                          w_load_b;
    logic                          w_load_c;
    logic                          w_capture;
    logic                          w_res_fire;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= LOAD_A;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_in_ready  = 1'b0;
        w_res_valid = 1'b0;
        w_load_a    = 1'b0;
        w_load_b    = 1'b0;
        w_load_c    = 1'b0;
        w_capture   = 1'b0;
        w_res_fire  = 1'b0;
        unique case (r_state)
            LOAD_A: begin
                w_in_ready = 1'b1;
                w_load_a   = in_valid;
                if (in_valid) w_next = LOAD_B;
            end
            LOAD_B: begin
                w_in_ready = 1'b1;
                w_load_b   = in_valid;
                if (in_valid) w_next = LOAD_C;
            end
            LOAD_C: begin
                w_in_ready = 1'b1;
                w_load_c   = in_valid;
                if (in_valid) w_next = SETTLE;
            end
            // circuit2 registers x/z at the end of this cycle
            SETTLE: begin
                w_next = CAPTURE;
            end
            CAPTURE: begin
                w_capture = 1'b1;
                w_next    = OUT;
            end
            OUT: begin
                w_res_valid = 1'b1;
                w_res_fire  = res_ready;
                if (res_ready) w_next = LOAD_A;
            end
            default: begin
                w_next = LOAD_A;
            end
        endcase
    end

    // Operands change only on their own accept edge, so a partial reload mixes triples.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
            r_res_z <= '0;
            r_res_x <= '0;
            r_count <= '0;
        end else begin
            if (w_load_a) r_a <= in_data;
            if (w_load_b) r_b <= in_data;
            if (w_load_c) r_c <= in_data;
            if (w_capture) begin
                r_res_z <= z_in;
                r_res_x <= x_in;
            end
            if (w_res_fire) r_count <= r_count + CNTWIDTH'(1);
        end
    end

    assign in_ready     = w_in_ready;
    assign res_valid    = w_res_valid;
    assign busy         = (r_state != LOAD_A);
    assign a            = r_a;
    assign b            = r_b;
    assign c            = r_c;
    assign res_z        = r_res_z;
    assign res_x        = r_res_x;
    assign triple_count = r_count;

endmodule

// File: tb/tb_circuit2_operand_sequencer.sv
// Scoreboard bench for circuit2_operand_sequencer with a behavioural circuit2 behind it.
module tb_circuit2_operand_sequencer;

    localparam int DW = 32;
    localparam int CW = 4;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic signed [DW-1:0] in_data = '0;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic signed [DW-1:0] a, b, c;
    logic signed [DW-1:0] z_in = '0;
    logic signed [DW-1:0] x_in = '0;
    logic signed [DW-1:0] res_z, res_x;
    logic                 res_valid;
    logic                 res_ready = 1'b0;
    logic                 busy;
    logic [CW-1:0]        triple_count;

    typedef struct {
        logic signed [DW-1:0] z;
        logic signed [DW-1:0] x;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   exp_cnt  = 0;

    circuit2_operand_sequencer #(.DATAWIDTH(DW), .CNTWIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c),
        .z_in(z_in), .x_in(x_in),
        .res_z(res_z), .res_x(res_x),
        .res_valid(res_valid), .res_ready(res_ready),
        .busy(busy), .triple_count(triple_count)
    );

    always #5 clk = ~clk;

    // circuit2 stand-in: d=a+b, e=a+c; x = d<<(d<e), z = d>>>(d==e), one register stage
    function automatic logic signed [DW-1:0] m_x(input logic signed [DW-1:0] ia, ib, ic);
        logic signed [DW-1:0] d, e;
        d = ia + ib;
        e = ia + ic;
        return (d < e) ? (d <<< 1) : d;
    endfunction

    function automatic logic signed [DW-1:0] m_z(input logic signed [DW-1:0] ia, ib, ic);
        logic signed [DW-1:0] d, e;
        d = ia + ib;
        e = ia + ic;
        return (d == e) ? (d >>> 1) : d;
    endfunction

    always_ff @(posedge clk) begin
        x_in <= m_x(a, b, c);
        z_in <= m_z(a, b, c);
    end

    task automatic chk(input string name, input longint act, input longint expv);
        n_checks++;
        if (act == expv) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, expv);
    endtask

    // Monitor: pops the oldest expectation on every downstream handshake.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_z", res_z, e.z);
                    chk("res_x", res_x, e.x);
                end
            end
        end
    end

    task automatic send_word(input logic signed [DW-1:0] w);
        int n = 0;
        in_data  = w;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("in_ready_timeout", 0, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic send_triple(input int ia, ib, ic, ez, ex);
        exp_t e;
        e.z = DW'(ez);
        e.x = DW'(ex);
        exp_q.push_back(e);
        send_word(DW'(ia));
        send_word(DW'(ib));
        send_word(DW'(ic));
    endtask

    task automatic wait_res_valid();
        int n = 0;
        while (!res_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk("res_valid_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) chk("idle_timeout", 0, 1);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_a"}, a, 0);
        chk({tag, "_b"}, b, 0);
        chk({tag, "_c"}, c, 0);
        chk({tag, "_res_z"}, res_z, 0);
        chk({tag, "_res_x"}, res_x, 0);
        chk({tag, "_count"}, triple_count, 0);
        chk({tag, "_res_valid"}, res_valid, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_in_ready"}, in_ready, 1);
    endtask

    initial begin
        logic signed [DW-1:0] snap_z, snap_x;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk_reset_state("reset");

        // Basic triple with latency check
        res_ready = 1'b1;
        send_triple(5, 3, 2, 8, 8);
        chk("settle_valid", res_valid, 0);
        chk("settle_in_ready", in_ready, 0);
        chk("settle_busy", busy, 1);
        @(posedge clk); #1;
        chk("capture_valid", res_valid, 0);
        @(posedge clk); #1;
        chk("out_valid", res_valid, 1);
        chk("out_in_ready", in_ready, 0);
        wait_idle();
        exp_cnt = 1;
        chk("count_1", triple_count, exp_cnt);

        send_triple(1, 2, 5, 3, 6);
        wait_idle();
        send_triple(4, 3, 3, 3, 7);
        wait_idle();
        send_triple(-8, 2, 3, -6, -12);
        wait_idle();
        exp_cnt += 3;
        chk("count_4", triple_count, exp_cnt);

        // Backpressure in OUT with in_valid held high
        res_ready = 1'b0;
        send_triple(7, 1, 1, 4, 8);
        wait_res_valid();
        snap_z   = res_z;
        snap_x   = res_x;
        in_data  = 99;
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_in_ready", in_ready, 0);
            chk("bp_res_z", res_z, snap_z);
            chk("bp_res_x", res_x, snap_x);
        end
        chk("bp_a", a, 7);
        chk("bp_b", b, 1);
        chk("bp_c", c, 1);
        chk("bp_count", triple_count, exp_cnt);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        wait_idle();
        exp_cnt++;
        chk("bp_count_after", triple_count, exp_cnt);
        send_triple(1, 2, 5, 3, 6);
        wait_idle();
        exp_cnt++;

        // Reset while in LOAD_C
        send_word(10);
        send_word(20);
        chk("loadc_busy", busy, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("rst_loadc");
        exp_cnt = 0;
        send_triple(5, 3, 2, 8, 8);
        wait_idle();
        exp_cnt++;
        chk("after_rst_loadc_count", triple_count, exp_cnt);

        // Reset while a result is pending in OUT
        res_ready = 1'b0;
        send_word(1);
        send_word(2);
        send_word(5);
        wait_res_valid();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk_reset_state("rst_out");
        exp_cnt   = 0;
        res_ready = 1'b1;
        send_triple(4, 3, 3, 3, 7);
        wait_idle();
        exp_cnt++;
        chk("after_rst_out_count", triple_count, exp_cnt);

        // Counter wrap at CNTWIDTH=4
        for (int i = 0; i < 14; i++) begin
            send_triple(2, 1, 1, 1, 3);
            wait_idle();
        end
        chk("count_15", triple_count, 15);
        send_triple(2, 1, 1, 1, 3);
        wait_idle();
        chk("count_wrap", triple_count, 0);

        repeat (3) @(posedge clk);
        #1 chk("scoreboard_empty", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
